// File: rtl/led_sched_pkg.sv
// led_sched_pkg
// Shared definitions for the LED alarm scheduler: requester count, blink
// code width, gap length in time units, the FSM state encoding and two small
// helpers used by the arbiter (priority pick and blink-code normalisation).
package led_sched_pkg;

    localparam int N_REQ     = 4;
    localparam int GAP_UNITS = 4;
    localparam int PAT_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Lowest set index wins; returns 0 when nothing is set (callers gate on |req).
    function automatic logic [1:0] prio_idx(input logic [N_REQ-1:0] r);
        logic [1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Blink code of requester idx, with a zero code treated as one pulse.
    function automatic logic [PAT_W-1:0] pat_of(input logic [N_REQ*PAT_W-1:0] pats,
                                                input logic [1:0] idx);
        logic [PAT_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == 2'(i)) p = pats[PAT_W*i +: PAT_W];
        end
        if (p == '0) p = PAT_W'(1);
        return p;
    endfunction

endpackage

// File: rtl/led_unit_timer.sv
// led_unit_timer
// Prescaler that divides the clock into blink time units of T_UNIT cycles.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-high reset
//   clear     - synchronous clear of the count (held while the scheduler idles)
//   enable    - count advances only while high
//   unit_tick - high for the single cycle in which the count sits at T_UNIT-1;
//               the count wraps to 0 on the following edge
module led_unit_timer #(
    parameter logic [24:0] T_UNIT = 25'd12_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic unit_tick
);

    logic [24:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == T_UNIT - 25'd1) cnt <= '0;
            else                       cnt <= cnt + 25'd1;
        end
    end

    assign unit_tick = enable && (cnt == T_UNIT - 25'd1);

endmodule

// File: rtl/led_alarm_sched.sv
// led_alarm_sched
// Shares one status LED between four requesters. The lowest-index active
// requester is granted and its 3-bit blink code is shown as P pulses of one
// unit on / one unit off, followed by a four-unit dark gap. Arbitration only
// happens from IDLE or at the end of the gap; a granted requester that lets
// go of its request aborts the sequence back to IDLE.
// Ports:
//   clock       - system clock, rising edge
//   reset       - asynchronous active-high reset
//   req         - request lines, bit 0 highest priority
//   req_pattern - 3-bit pulse count per requester, bits [3i+2:3i]
//   grant       - one-hot requester being displayed (registered)
//   busy        - high whenever the FSM is not idle (registered)
//   led         - {|req, grant, blink}
//   dbg_state   - current FSM state, for observation only
// Handshake: there is none; req is a level that must be held for the whole
// sequence, and dropping it is the only way to cancel.
module led_alarm_sched
    import led_sched_pkg::*;
#(
    parameter logic [24:0] T_UNIT = 25'd12_500_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PAT_W-1:0] req_pattern,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [5:0]             led,
    output state_t                 dbg_state
);

    localparam logic [1:0] GAP_LAST = 2'(GAP_UNITS - 1);

    state_t           state;
    logic             blink;
    logic [1:0]       cur_idx;
    logic [PAT_W-1:0] cur_pat;
    logic [PAT_W-1:0] pulse_cnt;
    logic [1:0]       gap_cnt;
    logic             unit_tick;

    logic [1:0]       win_idx;
    logic [PAT_W-1:0] win_pat;

    assign win_idx = prio_idx(req);
    assign win_pat = pat_of(req_pattern, win_idx);

    // Holding the prescaler clear in IDLE guarantees a full first unit after
    // any arbitration out of IDLE, including right after an abort.
    led_unit_timer #(.T_UNIT(T_UNIT)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == S_IDLE),
        .enable    (state != S_IDLE),
        .unit_tick (unit_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            blink     <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            cur_idx   <= '0;
            cur_pat   <= '0;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (|req) begin
                state     <= S_ON;
                blink     <= 1'b1;
                grant     <= 4'b0001 << win_idx;
                busy      <= 1'b1;
                cur_idx   <= win_idx;
                cur_pat   <= win_pat;
                pulse_cnt <= '0;
                gap_cnt   <= '0;
            end
        end else if (!req[cur_idx]) begin
            // Granted requester withdrew: abort without finishing the code.
            state <= S_IDLE;
            blink <= 1'b0;
            grant <= '0;
            busy  <= 1'b0;
        end else if (unit_tick) begin
            case (state)
                S_ON: begin
                    state <= S_OFF;
                    blink <= 1'b0;
                end
                S_OFF: begin
                    if (pulse_cnt + 3'd1 == cur_pat) begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end else begin
                        state     <= S_ON;
                        blink     <= 1'b1;
                        pulse_cnt <= pulse_cnt + 3'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        // req[cur_idx] is high here, so a winner always exists.
                        state     <= S_ON;
                        blink     <= 1'b1;
                        grant     <= 4'b0001 << win_idx;
                        cur_idx   <= win_idx;
                        cur_pat   <= win_pat;
                        pulse_cnt <= '0;
                        gap_cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign led       = {|req, grant, blink};
    assign dbg_state = state;

endmodule

// File: tb/tb_led_alarm_sched.sv
module tb_led_alarm_sched;
  import led_sched_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_pattern;
  logic [3:0]  grant;
  logic        busy;
  logic [5:0]  led;
  state_t      dbg_state;

  int checks;
  int failures;

  led_alarm_sched #(.T_UNIT(25'd4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_pattern (req_pattern),
    .grant       (grant),
    .busy        (busy),
    .led         (led),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b0000;
    req_pattern = 12'd0;
    step();
    step();
    checks++;
    if (led !== 6'b000000 || busy !== 1'b0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs led=%b busy=%b grant=%b required led=000000 busy=0 grant=0000", led, busy, grant);
    end
    reset = 1'b0;
    step();
    checks++;
    if (led !== 6'b000000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle led=%b busy=%b required led=000000 busy=0", led, busy);
    end
  endtask

  // requester 2, code 3: 3x(4 on, 4 off) + 16 dark = 40 cycles; pattern
  // edits mid-sequence must not change the pulse count
  task automatic test_single();
    logic eb;
    req_pattern = 12'd0;
    req_pattern[8:6] = 3'd3;
    req = 4'b0100;
    step();
    for (int k = 0; k < 80; k++) begin
      eb = ((k % 40) < 24) && ((k % 8) < 4);
      checks++;
      if (blink_of() !== eb || grant !== 4'b0100 || busy !== 1'b1 || led[5] !== 1'b1) begin
        failures++;
        $display("FAIL single k=%0d blink=%b grant=%b busy=%b led=%b required blink=%b grant=0100 busy=1", k, blink_of(), grant, busy, led, eb);
      end
      if (k == 5)  req_pattern[8:6] = 3'd1;
      if (k == 30) req_pattern[8:6] = 3'd3;
      step();
    end
    go_idle();
  endtask

  function automatic logic blink_of();
    return led[0];
  endfunction

  // requesters 0 and 3 together: 0 wins with code 2, period 32
  task automatic test_simultaneous();
    logic eb;
    req_pattern = 12'd0;
    req_pattern[2:0]  = 3'd2;
    req_pattern[11:9] = 3'd5;
    req = 4'b1001;
    step();
    for (int k = 0; k < 64; k++) begin
      eb = ((k % 32) < 16) && ((k % 8) < 4);
      checks++;
      if (blink_of() !== eb || grant !== 4'b0001 || led[4:1] !== 4'b0001) begin
        failures++;
        $display("FAIL simultaneous k=%0d blink=%b grant=%b required blink=%b grant=0001", k, blink_of(), grant, eb);
      end
      step();
    end
    go_idle();
  endtask

  // requester 3 code 4 (48 cycles); requester 1 rises in pulse 2 and waits
  task automatic test_no_preempt();
    logic       eb;
    logic [3:0] eg;
    req_pattern = 12'd0;
    req_pattern[11:9] = 3'd4;
    req_pattern[5:3]  = 3'd1;
    req = 4'b1000;
    step();
    for (int k = 0; k < 53; k++) begin
      if (k < 48) begin
        eg = 4'b1000;
        eb = (k < 32) && ((k % 8) < 4);
      end else begin
        eg = 4'b0010;
        eb = (k - 48) < 4;
      end
      checks++;
      if (blink_of() !== eb || grant !== eg) begin
        failures++;
        $display("FAIL no_preempt k=%0d blink=%b grant=%b required blink=%b grant=%b", k, blink_of(), grant, eb, eg);
      end
      if (k == 9) req = 4'b1010;
      step();
    end
    go_idle();
  endtask

  // drop the granted request in ON, then re-request right away
  task automatic test_drop();
    logic eb;
    req_pattern = 12'd0;
    req_pattern[5:3] = 3'd2;
    req = 4'b0010;
    step();
    step();
    step();
    checks++;
    if (blink_of() !== 1'b1 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL drop_pre blink=%b grant=%b required blink=1 grant=0010", blink_of(), grant);
    end
    req = 4'b0000;
    step();
    checks++;
    if (led !== 6'b000000 || busy !== 1'b0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL drop_abort led=%b busy=%b grant=%b required led=000000 busy=0 grant=0000", led, busy, grant);
    end
    req = 4'b0010;
    step();
    for (int k = 0; k < 8; k++) begin
      eb = k < 4;
      checks++;
      if (blink_of() !== eb || grant !== 4'b0010 || busy !== 1'b1) begin
        failures++;
        $display("FAIL drop_restart k=%0d blink=%b grant=%b busy=%b required blink=%b grant=0010 busy=1", k, blink_of(), grant, busy, eb);
      end
      step();
    end
    go_idle();
  endtask

  // code 0 on requester 2 behaves as a single pulse, period 24
  task automatic test_pattern_zero();
    logic eb;
    req_pattern = 12'd0;
    req = 4'b0100;
    step();
    for (int k = 0; k < 48; k++) begin
      eb = (k % 24) < 4;
      checks++;
      if (blink_of() !== eb || grant !== 4'b0100) begin
        failures++;
        $display("FAIL pattern_zero k=%0d blink=%b grant=%b required blink=%b grant=0100", k, blink_of(), grant, eb);
      end
      step();
    end
    go_idle();
  endtask

  // reset in the first OFF phase, then a clean sequence after release
  task automatic test_reset_mid();
    logic eb;
    req_pattern = 12'd0;
    req_pattern[8:6] = 3'd3;
    req = 4'b0100;
    step();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (blink_of() !== 1'b0 || busy !== 1'b1 || dbg_state !== S_OFF) begin
      failures++;
      $display("FAIL reset_mid_pre blink=%b busy=%b state=%0d required blink=0 busy=1 state=%0d", blink_of(), busy, dbg_state, S_OFF);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (led[4:0] !== 5'b00000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async led=%b busy=%b required led[4:0]=00000 busy=0", led, busy);
    end
    step();
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 40; k++) begin
      eb = (k < 24) && ((k % 8) < 4);
      checks++;
      if (blink_of() !== eb || grant !== 4'b0100) begin
        failures++;
        $display("FAIL reset_mid_after k=%0d blink=%b grant=%b required blink=%b grant=0100", k, blink_of(), grant, eb);
      end
      step();
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req = 4'b0000;
    req_pattern = 12'd0;
    test_reset();
    test_single();
    test_simultaneous();
    test_no_preempt();
    test_drop();
    test_pattern_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
